load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// Sits directly downstream of the ALU in the execute stage. It consumes ALUResult as the effective address for
// RV32I loads and stores, and drives a word-wide data-memory bus with a req/ack handshake. It applies byte
// enables and store-data lane replication, and sign- or zero-extends load data. While an access is in flight it
// stalls the core. Misaligned accesses, illegal funct3 values and bus timeouts are reported as faults.
// PARAMETERS
// TIMEOUT   255   max ACCESS cycles waiting for dmem_ack before fault; must be >= 1
// CNT_W     8     timeout counter width; must be >= $clog2(TIMEOUT+1)
// PORTS
// clk         in   1   core clock; all state on rising edge
// reset       in   1   asynchronous, active-high reset
// mem_en      in   1   execute-stage instruction is a load/store; request sampled in IDLE
// mem_we      in   1   1=store, 0=load
// funct3      in   3   RV32I width/sign field
// addr        in   32  effective address (ALUResult)
// wdata       in   32  store data (rs2)
// stall       out  1   hold pipeline; core advances only on cycles where stall=0
// rdata       out  32  extended load result; valid when resp_valid=1
// resp_valid  out  1   one-cycle pulse in RESP
// fault       out  1   qualifies resp_valid: misaligned, illegal funct3 or timeout
// dmem_req    out  1   bus request, registered
// dmem_we     out  1   bus write strobe
// dmem_addr   out  32  word address {addr[31:2],2'b00}
// dmem_be     out  4   byte enables
// dmem_wdata  out  32  lane-replicated store data
// dmem_ack    in   1   bus completion, sampled on clk
// dmem_rdata  in   32  read word, valid with dmem_ack
// BEHAVIOUR
// - Reset: state=IDLE; all outputs and latched registers 0; stall=0. Reset mid-access drops dmem_req
//   immediately and discards the access.
// - FSM states: IDLE, ACCESS, RESP.
// - IDLE:
//   - stall = mem_en (combinational).
//   - If mem_en, latch addr, wdata, funct3 and mem_we.
//   - Legal and aligned: go to ACCESS. Otherwise: go to RESP with fault=1 and no bus activity.
// - Legal funct3:
//   - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
//   - stores: 000 SB, 001 SH, 010 SW.
//   - Anything else faults.
// - Alignment:
//   - halfword requires addr[0]=0; word requires addr[1:0]=00.
//   - Misaligned accesses fault and never reach the bus.
// - ACCESS:
//   - dmem_req=1; dmem_we, dmem_addr, dmem_be and dmem_wdata held stable; stall=1; counter increments.
//   - dmem_ack sampled high: go to RESP with fault=0; loads capture dmem_rdata.
//   - Counter reaches TIMEOUT without ack: go to RESP with fault=1.
//   - dmem_req deasserts on leaving ACCESS.
// - RESP (one cycle):
//   - resp_valid=1, stall=0, then go to IDLE unconditionally.
//   - mem_en seen in RESP is ignored; the next request is sampled in IDLE.
//   - Faulted loads return rdata=0. For stores, rdata=0.
// - Byte enables:
//   - SB: be = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
//   - SH: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
//   - SW: be = 1111.
//   - Loads: be=1111.
// - Load extension:
//   - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
//   - Sign-extend from bit 7/15 for LB/LH; zero-extend for LBU/LHU.
// - Latency:
//   - Aligned access with ack in the first ACCESS cycle: stall high 2 cycles, resp_valid in 3rd cycle.
//   - Each bus wait state adds 1 cycle.
//   - Fault without bus activity: stall 1 cycle, resp_valid next cycle.
// - dmem_ack outside ACCESS is ignored.
// TESTING
// - SW addr=0x100, wdata=0xDEADBEEF, ack in 1st ACCESS cycle -> dmem_addr=0x100, be=1111, stall 2 cycles,
//   resp_valid with fault=0.
// - LB addr=0x203, dmem_rdata=0x80FF1234 -> rdata=0xFFFFFF80. LBU same -> 0x00000080.
// - LHU addr=0x202, 3 wait states, rdata=0x9ABC0000 -> dmem_req held 4 cycles, rdata=0x00009ABC.
// - SB addr=0x301, wdata=0x000000A5 -> be=0010, dmem_wdata=0xA5A5A5A5.
// - LW addr=0x102 -> no dmem_req, stall 1 cycle, fault=1; funct3=011 -> same fault path.
// - No ack, TIMEOUT=4 -> fault after 4 ACCESS cycles. Separately, reset asserted in ACCESS -> dmem_req=0
//   immediately, IDLE, no resp_valid.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with req/ack data-memory bus
//
// Purpose: takes the ALU result as the effective address for loads and stores.
// Drives a word-wide data-memory bus with byte enables and lane-replicated
// store data, and returns sign- or zero-extended load data. Misaligned
// accesses, illegal funct3 values and bus timeouts are returned as faults.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   mem_en, mem_we, funct3  request from the execute stage, sampled in IDLE
//   addr, wdata             effective address and store data (rs2)
//   stall                   holds the pipeline while a request is pending
//   rdata, resp_valid,      one-cycle response; fault qualifies resp_valid
//   fault
//   dmem_req, dmem_we,      data-memory bus request side
//   dmem_addr, dmem_be,
//   dmem_wdata
//   dmem_ack, dmem_rdata    data-memory bus completion side

module load_store_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        resp_valid,
  output logic        fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic [2:0]         funct3_q, funct3_d;
  logic               we_q, we_d;
  logic               req_q, req_d;
  logic               fault_q, fault_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               legal_c;
  logic               aligned_c;
  logic [3:0]         be_c;
  logic [31:0]        wdata_c;
  logic [31:0]        lane_c;
  logic [15:0]        half_c;
  logic [31:0]        load_c;

  // Request decode works on the live inputs: it only matters in IDLE.
  always_comb begin
    legal_c   = 1'b0;
    aligned_c = 1'b1;
    be_c      = 4'b1111;
    wdata_c   = 32'h0;
    if (mem_we) begin
      legal_c = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      legal_c = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    // funct3[1:0] encodes access width for both loads and stores.
    if (funct3[1:0] == 2'b01) begin
      aligned_c = (addr[0] == 1'b0);
    end else if (funct3[1:0] == 2'b10) begin
      aligned_c = (addr[1:0] == 2'b00);
    end
    if (mem_we) begin
      case (funct3[1:0])
        2'b00: begin
          be_c    = 4'b0001 << addr[1:0];
          wdata_c = {4{wdata[7:0]}};
        end
        2'b01: begin
          be_c    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{wdata[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = wdata;
        end
      endcase
    end
  end

  // Load extraction uses the latched address and funct3.
  always_comb begin
    lane_c = dmem_rdata >> {addr_q[1:0], 3'b000};
    half_c = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_c = {{24{lane_c[7]}}, lane_c[7:0]};
      3'b100:  load_c = {24'h0, lane_c[7:0]};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b101:  load_c = {16'h0, half_c};
      default: load_c = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    req_d    = req_q;
    fault_d  = fault_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;

    case (state_q)
      IDLE: begin
        stall = mem_en;
        if (mem_en) begin
          addr_d   = addr;
          wdata_d  = wdata_c;
          be_d     = be_c;
          funct3_d = funct3;
          we_d     = mem_we;
          rdata_d  = 32'h0;
          cnt_d    = '0;
          if (legal_c && aligned_c) begin
            state_d = ACCESS;
            req_d   = 1'b1;
            fault_d = 1'b0;
          end else begin
            // Bad requests skip the bus entirely.
            state_d = RESP;
            req_d   = 1'b0;
            fault_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (dmem_ack) begin
          state_d = RESP;
          req_d   = 1'b0;
          fault_d = 1'b0;
          rdata_d = we_q ? 32'h0 : load_c;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th cycle spent waiting.
          state_d = RESP;
          req_d   = 1'b0;
          fault_d = 1'b1;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      be_q     <= 4'h0;
      funct3_q <= 3'h0;
      we_q     <= 1'b0;
      req_q    <= 1'b0;
      fault_q  <= 1'b0;
      rdata_q  <= 32'h0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      req_q    <= req_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q & req_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign resp_valid = (state_q == RESP);
  assign fault      = resp_valid & fault_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed-vector bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_en = 1'b0;
  logic        mem_we = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall;
  logic [31:0] rdata;
  logic        resp_valid;
  logic        fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;

  int tests_run = 0;
  int tests_failed = 0;

  int          stall_cnt, req_cnt, resp_cyc, bad_cnt;
  logic        got_resp, r_fault, cap_we;
  logic [31:0] r_rdata, cap_addr, cap_wd;
  logic [3:0]  cap_be;

  load_store_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .mem_en(mem_en), .mem_we(mem_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
    .rdata(rdata), .resp_valid(resp_valid), .fault(fault),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // waits < 0 means never acknowledge.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int waits, input logic [31:0] rd_word);
    stall_cnt = 0; req_cnt = 0; resp_cyc = -1; got_resp = 1'b0;
    r_fault = 1'b0; r_rdata = 32'h0; cap_we = 1'b0;
    cap_addr = 32'h0; cap_wd = 32'h0; cap_be = 4'h0;
    @(negedge clk);
    mem_en = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
    dmem_ack = 1'b0; dmem_rdata = rd_word;
    for (int cyc = 0; cyc < 20 && !got_resp; cyc++) begin
      #1;
      if (stall) stall_cnt++;
      if (dmem_req) begin
        req_cnt++;
        cap_be = dmem_be; cap_wd = dmem_wdata; cap_addr = dmem_addr; cap_we = dmem_we;
        if (waits >= 0 && req_cnt == waits + 1) dmem_ack = 1'b1;
      end
      if (resp_valid) begin
        got_resp = 1'b1; r_fault = fault; r_rdata = rdata; resp_cyc = cyc;
      end
      @(negedge clk);
      mem_en = 1'b0; dmem_ack = 1'b0;
    end
    check("resp_seen", {31'h0, got_resp}, 32'h1);
  endtask

  initial begin
    #12;
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_req", {31'h0, dmem_req}, 32'h0);
    check("rst_resp", {31'h0, resp_valid}, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_be", {28'h0, dmem_be}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // SW, ack in the first ACCESS cycle
    do_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0);
    check("sw_addr", cap_addr, 32'h100);
    check("sw_be", {28'h0, cap_be}, 32'hF);
    check("sw_wdata", cap_wd, 32'hDEADBEEF);
    check("sw_we", {31'h0, cap_we}, 32'h1);
    check("sw_stall", stall_cnt, 2);
    check("sw_lat", resp_cyc, 2);
    check("sw_fault", {31'h0, r_fault}, 32'h0);

    // LB / LBU, byte lane 3
    do_access(1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80FF1234);
    check("lb_rdata", r_rdata, 32'hFFFFFF80);
    check("lb_addr", cap_addr, 32'h200);
    check("lb_be", {28'h0, cap_be}, 32'hF);
    check("lb_we", {31'h0, cap_we}, 32'h0);
    do_access(1'b0, 3'b100, 32'h203, 32'h0, 0, 32'h80FF1234);
    check("lbu_rdata", r_rdata, 32'h00000080);

    // LHU, 3 wait states; ack lands on the last allowed cycle before timeout
    do_access(1'b0, 3'b101, 32'h202, 32'h0, 3, 32'h9ABC0000);
    check("lhu_req", req_cnt, 4);
    check("lhu_rdata", r_rdata, 32'h00009ABC);
    check("lhu_stall", stall_cnt, 5);
    check("lhu_fault", {31'h0, r_fault}, 32'h0);

    // LH, upper half, negative
    do_access(1'b0, 3'b001, 32'h202, 32'h0, 1, 32'h80001234);
    check("lh_rdata", r_rdata, 32'hFFFF8000);
    check("lh_lat", resp_cyc, 3);

    // SB lane 1
    do_access(1'b1, 3'b000, 32'h301, 32'h000000A5, 0, 32'h0);
    check("sb_be", {28'h0, cap_be}, 32'h2);
    check("sb_wdata", cap_wd, 32'hA5A5A5A5);
    check("sb_addr", cap_addr, 32'h300);

    // SH upper half
    do_access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 0, 32'h0);
    check("sh_be", {28'h0, cap_be}, 32'hC);
    check("sh_wdata", cap_wd, 32'hABCDABCD);
    check("sh_rdata", r_rdata, 32'h0);

    // Misaligned LW
    do_access(1'b0, 3'b010, 32'h102, 32'h0, 0, 32'hFFFFFFFF);
    check("mis_req", req_cnt, 0);
    check("mis_stall", stall_cnt, 1);
    check("mis_fault", {31'h0, r_fault}, 32'h1);
    check("mis_lat", resp_cyc, 1);
    check("mis_rdata", r_rdata, 32'h0);

    // Illegal load funct3
    do_access(1'b0, 3'b011, 32'h100, 32'h0, 0, 32'hFFFFFFFF);
    check("ill_req", req_cnt, 0);
    check("ill_fault", {31'h0, r_fault}, 32'h1);
    check("ill_stall", stall_cnt, 1);

    // Illegal store funct3 (100 is load-only)
    do_access(1'b1, 3'b100, 32'h100, 32'h0, 0, 32'h0);
    check("ills_req", req_cnt, 0);
    check("ills_fault", {31'h0, r_fault}, 32'h1);

    // Timeout with TIMEOUT=4
    do_access(1'b0, 3'b010, 32'h40, 32'h0, -1, 32'h12345678);
    check("to_req", req_cnt, 4);
    check("to_fault", {31'h0, r_fault}, 32'h1);
    check("to_rdata", r_rdata, 32'h0);
    check("to_lat", resp_cyc, 5);

    // Stray ack in IDLE is ignored
    @(negedge clk);
    dmem_ack = 1'b1;
    @(negedge clk);
    #1;
    check("stray_req", {31'h0, dmem_req}, 32'h0);
    check("stray_resp", {31'h0, resp_valid}, 32'h0);
    check("stray_stall", {31'h0, stall}, 32'h0);
    dmem_ack = 1'b0;

    // Reset asserted mid-ACCESS
    @(negedge clk);
    mem_en = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h80;
    @(negedge clk);
    mem_en = 1'b0;
    #1;
    check("rstm_pre_req", {31'h0, dmem_req}, 32'h1);
    reset = 1'b1;
    #1;
    check("rstm_req", {31'h0, dmem_req}, 32'h0);
    check("rstm_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bad_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (resp_valid || dmem_req || stall) bad_cnt++;
    end
    check("rstm_quiet", bad_cnt, 0);

    // Normal operation after mid-access reset
    do_access(1'b0, 3'b010, 32'h84, 32'h0, 0, 32'hCAFEF00D);
    check("post_rdata", r_rdata, 32'hCAFEF00D);
    check("post_fault", {31'h0, r_fault}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
